// File: rtl/sync_word_deframer_pkg.sv
// Shared types and constants for the sync-word deframer.
// State encoding, sync window width and the default sync nibble.
package deframer_pkg;

  localparam int SYNC_W = 4;
  localparam logic [SYNC_W-1:0] DEFAULT_SYNC_PATTERN = 4'b1011;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    PAYLOAD  = 2'd1,
    SYNC_CHK = 2'd2
  } state_e;

  // The bit counter is shared with the 4-bit sync slot, so it needs at least 2 bits.
  function automatic int cnt_width(input int payload_bits);
    int w;
    w = $clog2(payload_bits);
    return (w < 2) ? 2 : w;
  endfunction

endpackage

// File: rtl/sync_word_deframer_if.sv
// Bus between the shift stage / consumer and the deframer.
// frame_count exists only when FRAME_COUNT_EN is defined.
interface sync_word_deframer_if #(
  parameter int PAYLOAD_BITS = 8
);

  logic [deframer_pkg::SYNC_W-1:0] window;
  logic                            in_valid;
  logic [PAYLOAD_BITS-1:0]         data_out;
  logic                            data_valid;
  logic                            locked;
  logic                            sync_err;
`ifdef FRAME_COUNT_EN
  logic [15:0]                     frame_count;

  modport master (
    output window, in_valid,
    input  data_out, data_valid, locked, sync_err, frame_count
  );

  modport slave (
    input  window, in_valid,
    output data_out, data_valid, locked, sync_err, frame_count
  );
`else
  modport master (
    output window, in_valid,
    input  data_out, data_valid, locked, sync_err
  );

  modport slave (
    input  window, in_valid,
    output data_out, data_valid, locked, sync_err
  );
`endif

endinterface

// File: rtl/sync_word_deframer_sipo.sv
// Payload shift register plus the held output word.
// The word is loaded with the final bit folded in, on the same edge that shifts it.
module deframer_sipo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             load,
  output logic [WIDTH-1:0] word
);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;

  always_comb begin
    shift_d = shift_q;
    word_d  = word_q;
    if (shift_en) begin
      shift_d = {shift_q[WIDTH-2:0], bit_in};
    end
    if (load) begin
      word_d = {shift_q[WIDTH-2:0], bit_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      word_q  <= '0;
    end else begin
      shift_q <= shift_d;
      word_q  <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/sync_word_deframer.sv
// Sync-word deframer: hunts for the sync nibble, assembles payload words, flywheels over sync misses.
// Optional FRAME_COUNT_EN adds a wrapping 16-bit count of emitted words.
module sync_word_deframer
  import deframer_pkg::*;
#(
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = DEFAULT_SYNC_PATTERN,
  parameter int                PAYLOAD_BITS = 8,
  parameter int                LOSS_LIMIT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sync_word_deframer_if.slave   bus
);

  localparam int              CW        = cnt_width(PAYLOAD_BITS);
  localparam logic [CW-1:0]   LAST_PAY  = CW'(PAYLOAD_BITS - 1);
  localparam logic [CW-1:0]   LAST_SYNC = CW'(SYNC_W - 1);
  localparam logic [2:0]      LOSS      = 3'(LOSS_LIMIT);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      miss_q, miss_d;
  logic            locked_q, locked_d;
  logic            data_valid_q, data_valid_d;
  logic            sync_err_q, sync_err_d;
  logic            shift_en;
  logic            load;
  logic            sync_hit;
  logic [PAYLOAD_BITS-1:0] word;

  assign sync_hit = (bus.window == SYNC_PATTERN);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_d       = miss_q;
    locked_d     = locked_q;
    data_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    shift_en     = 1'b0;
    load         = 1'b0;
    if (bus.in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (sync_hit) begin
            state_d  = PAYLOAD;
            cnt_d    = '0;
            locked_d = 1'b1;
          end
        end
        PAYLOAD: begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_PAY) begin
            load         = 1'b1;
            data_valid_d = 1'b1;
            state_d      = SYNC_CHK;
            cnt_d        = '0;
          end
        end
        SYNC_CHK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_SYNC) begin
            cnt_d   = '0;
            state_d = PAYLOAD;
            if (sync_hit) begin
              miss_d = '0;
            end else begin
              // A miss alone keeps framing (flywheel); only a run of misses drops lock.
              sync_err_d = 1'b1;
              miss_d     = miss_q + 3'd1;
              if (miss_q + 3'd1 == LOSS) begin
                state_d  = HUNT;
                locked_d = 1'b0;
                miss_d   = '0;
              end
            end
          end
        end
        default: begin
          state_d  = HUNT;
          cnt_d    = '0;
          miss_d   = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HUNT;
      cnt_q        <= '0;
      miss_q       <= '0;
      locked_q     <= 1'b0;
      data_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      miss_q       <= miss_d;
      locked_q     <= locked_d;
      data_valid_q <= data_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  deframer_sipo #(
    .WIDTH (PAYLOAD_BITS)
  ) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .bit_in   (bus.window[0]),
    .load     (load),
    .word     (word)
  );

  assign bus.data_out   = word;
  assign bus.data_valid = data_valid_q;
  assign bus.locked     = locked_q;
  assign bus.sync_err   = sync_err_q;

`ifdef FRAME_COUNT_EN
  // Survives loss of lock; only reset clears it.
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (data_valid_d) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign bus.frame_count = frame_count_q;
`endif

endmodule

// File: doc/sync_word_deframer.md
Name: sync_word_deframer

Overview:
- Downstream consumer of the 4-bit serial-in/parallel-out shift stage.
- Watches the 4-bit shift window each cycle and hunts for a 4-bit sync pattern.
- After sync, collects PAYLOAD_BITS following serial bits into a word and emits it with a one-cycle valid pulse.
- Tracks lock through periodic sync checks; drops lock after LOSS_LIMIT consecutive sync misses.

Parameters:
SYNC_PATTERN, 4'b1011, sync nibble compared against the full window.
PAYLOAD_BITS, 8, payload bits per frame (legal range 2..32).
LOSS_LIMIT, 2, consecutive sync misses that force HUNT (legal range 1..7).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset; 0 = reset.
window  input  4  shift-stage parallel output; window[0] is the newest bit.
in_valid  input  1  1 = a new bit entered the window this cycle; 0 = stall.
data_out  output  PAYLOAD_BITS  assembled payload, first-received bit in MSB.
data_valid  output  1  one-cycle pulse; data_out is valid while high.
locked  output  1  high while framing is locked.
sync_err  output  1  one-cycle pulse on each sync-check mismatch.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; state=HUNT; bit counter=0; miss counter=0; payload register=0.
- All state advances happen only on edges with in_valid=1. With in_valid=0, state, counters and outputs hold, except that data_valid and sync_err clear to 0.
- HUNT:
  - locked=0.
  - window==SYNC_PATTERN: go to PAYLOAD, cnt=0, locked=1 next cycle.
- PAYLOAD:
  - Each valid edge shifts window[0] into the payload LSB (older bits move toward the MSB); cnt++.
  - On the edge where cnt==PAYLOAD_BITS-1:
    - data_out is loaded with the completed word and data_valid=1 for the following cycle.
    - Go to SYNC_CHK, cnt=0.
  - Latency: data_valid is high in the cycle after the edge that samples the last payload bit.
- SYNC_CHK:
  - Counts 4 valid bits. On the 4th valid edge (cnt==3), compare window with SYNC_PATTERN.
  - Match: miss=0, go to PAYLOAD.
  - Mismatch: sync_err=1 next cycle, miss++.
    - If the new miss count equals LOSS_LIMIT: go to HUNT, locked=0, miss=0.
    - Otherwise go to PAYLOAD (flywheel: the frame is still captured).
- While locked, a sync pattern appearing inside the payload is ignored (no resync).
- data_out holds its last value between pulses.
- Reset asserted mid-frame aborts the frame immediately. No data_valid pulse for a partial word.
- Counter width: clog2(PAYLOAD_BITS). Miss counter: 3 bits.
- Counters are cleared on every state entry, so no wrap-around occurs.

Optional Feature:
- Macro FRAME_COUNT_EN.
- Defined:
  - Adds output frame_count[15:0], reset 0.
  - Increments on every data_valid pulse (same edge that sets data_valid) and wraps 16'hFFFF -> 0.
  - Not cleared on loss of lock.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package deframer_pkg:
  - state encoding constants HUNT=2'd0, PAYLOAD=2'd1, SYNC_CHK=2'd2.
  - SYNC_W=4 and default SYNC_PATTERN.
- Sub-module deframer_sipo: payload shift register plus output register (inputs shift_en, bit, load; output word).
- FSM and counters stay in the top level.

Test Plan:
- Reset, then feed bits 1,0,1,1 then 1,0,1,0,0,1,0,1 with in_valid=1 -> data_out=8'hA5, data_valid high exactly 1 cycle; locked=1 from the cycle after the sync match.
- Continue with sync 1011 then payload 8'h3C -> second pulse with data_out=8'h3C, sync_err stays 0.
- Next sync slot 0000 then payload 8'hFF -> sync_err one pulse, locked stays 1, data_out=8'hFF. A second consecutive bad sync -> locked=0, state HUNT, no further pulses until 1011 is seen.
- Locked, payload 8'hB0 (contains 1011) -> single pulse with 8'hB0, no premature resync.
- Toggle in_valid=0 for 3 cycles mid-payload with payload 8'h5A -> word still 8'h5A, pulse delayed by exactly 3 cycles.
- Assert rst=0 asynchronously at payload bit 5 -> outputs 0 immediately; after release, no pulse until a fresh 1011 plus 8 bits.
